codec_reg_seq: RTL

CODEC_REG_SEQ -- requirements
Module: codec_reg_seq

---
 rtl/codec_reg_seq.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/codec_reg_seq.sv
// Audio codec boot-table and volume-update sequencer driving a single-write I2C master.
// Optional macro CODEC_SEQ_RETRY_EN adds bounded NACK retry per write.
module codec_reg_seq #(
  parameter int WL        = 16,
  parameter int PHONE_VOL = 30,
  parameter int SPEAK_VOL = 63,
  parameter int PWRUP_DLY = 252,
  parameter int RETRY_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  input  logic        vol_req,
  input  logic [5:0]  vol_phone,
  input  logic [5:0]  vol_speak,
  output logic        i2c_exec,
  output logic [15:0] i2c_data,
  output logic        init_done,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] LP_WL =
    (WL == 20) ? 2'b01 :
    (WL == 24) ? 2'b10 :
    (WL == 32) ? 2'b11 : 2'b00;
  localparam logic [15:0] LP_DLY_M1 = 16'(PWRUP_DLY - 1);
  localparam logic [5:0]  LP_PV     = 6'(PHONE_VOL);
  localparam logic [5:0]  LP_SV     = 6'(SPEAK_VOL);

  typedef enum logic [2:0] {
    S_DELAY, S_ISSUE, S_WAIT, S_DONE, S_VOL_ISSUE, S_VOL_WAIT
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_cnt;
  logic [4:0]  r_idx;
  logic [1:0]  r_vidx;
  logic [15:0] r_data;
  logic        r_init, r_err;
  logic [5:0]  r_pv, r_sv, r_ppv, r_psv;
  logic        r_pend;

  logic        w_retry, w_issue, w_wait;
  logic        w_dly_end, w_last, w_early, w_vlast;
  logic [4:0]  w_eidx;
  logic [15:0] w_entry;

  function automatic logic [15:0] f_entry(
    input logic [4:0] idx,
    input logic [5:0] pv,
    input logic [5:0] sv
  );
    logic [15:0] f;
    f = '0;
    case (idx)
      5'd0:  f = {7'd0,  9'h001};
      5'd1:  f = {7'd1,  9'h007};
      5'd2:  f = {7'd1,  9'h02F};
      5'd3:  f = {7'd2,  9'h1B3};
      5'd4:  f = {7'd4,  2'b00, LP_WL, 5'b10000};
      5'd5:  f = {7'd6,  9'h001};
      5'd6:  f = {7'd7,  9'h001};
      5'd7:  f = {7'd10, 9'h008};
      5'd8:  f = {7'd14, 9'h108};
      5'd9:  f = {7'd43, 9'h010};
      5'd10: f = {7'd47, 9'h070};
      5'd11: f = {7'd48, 9'h070};
      5'd12: f = {7'd49, 9'h006};
      5'd13: f = {7'd50, 9'h001};
      5'd14: f = {7'd51, 9'h001};
      5'd15: f = {7'd52, 3'b010, pv};
      5'd16: f = {7'd53, 3'b110, pv};
      5'd17: f = {7'd54, 3'b010, sv};
      5'd18: f = {7'd55, 3'b110, sv};
      5'd19: f = {7'd3,  9'h06F};
      default: f = '0;
    endcase
    return f;
  endfunction

  assign w_issue   = (r_state == S_ISSUE) || (r_state == S_VOL_ISSUE);
  assign w_wait    = (r_state == S_WAIT) || (r_state == S_VOL_WAIT);
  assign w_dly_end = (r_cnt == LP_DLY_M1);
  assign w_last    = (r_idx == 5'd19);
  assign w_early   = (r_idx < 5'd2);
  assign w_vlast   = (r_vidx == 2'd3);
  assign w_eidx    = (r_state == S_VOL_ISSUE) ?
                     5'd15 + {3'b000, r_vidx} : r_idx;
  assign w_entry   = f_entry(w_eidx, r_pv, r_sv);

  assign i2c_exec  = w_issue;
  assign i2c_data  = w_issue ? w_entry : r_data;
  assign busy      = (r_state != S_DONE);
  assign init_done = r_init;
  assign err       = r_err;

`ifdef CODEC_SEQ_RETRY_EN
  localparam logic [7:0] LP_RMAX = 8'(RETRY_MAX);
  logic [7:0] r_retry;

  assign w_retry = i2c_nack && (r_retry < LP_RMAX);

  // NACK retry counter, cleared whenever a write is finally accepted or dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry <= '0;
    end else if (w_wait && i2c_done) begin
      r_retry <= w_retry ? r_retry + 8'd1 : '0;
    end
  end
`else
  assign w_retry = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_DELAY;
    else        r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_DELAY:     if (w_dly_end) w_next = S_ISSUE;
      S_ISSUE:     w_next = S_WAIT;
      S_WAIT: begin
        if (i2c_done) begin
          if (w_retry)      w_next = S_ISSUE;
          else if (w_last)  w_next = S_DONE;
          else if (w_early) w_next = S_DELAY;
          else              w_next = S_ISSUE;
        end
      end
      S_DONE:      if (vol_req || r_pend) w_next = S_VOL_ISSUE;
      S_VOL_ISSUE: w_next = S_VOL_WAIT;
      S_VOL_WAIT: begin
        if (i2c_done) begin
          if (w_retry || !w_vlast) w_next = S_VOL_ISSUE;
          else                     w_next = S_DONE;
        end
      end
      default:     w_next = S_DELAY;
    endcase
  end

  // Sequencing datapath: delay count, table index, held data, status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_vidx <= '0;
      r_data <= '0;
      r_init <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_DELAY)
        r_cnt <= w_dly_end ? '0 : r_cnt + 16'd1;
      if (w_issue)
        r_data <= w_entry;
      if (r_state == S_WAIT && i2c_done && !w_retry) begin
        if (w_last) r_init <= 1'b1;
        else        r_idx  <= r_idx + 5'd1;
      end
      if (r_state == S_VOL_WAIT && i2c_done && !w_retry)
        r_vidx <= r_vidx + 2'd1;
      if (w_wait && i2c_done && i2c_nack && !w_retry)
        r_err <= 1'b1;
    end
  end

  // Volume registers and deferred request (latest values win)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv   <= LP_PV;
      r_sv   <= LP_SV;
      r_ppv  <= LP_PV;
      r_psv  <= LP_SV;
      r_pend <= 1'b0;
    end else if (r_state == S_DONE) begin
      if (vol_req) begin
        r_pv   <= vol_phone;
        r_sv   <= vol_speak;
        r_pend <= 1'b0;
      end else if (r_pend) begin
        r_pv   <= r_ppv;
        r_sv   <= r_psv;
        r_pend <= 1'b0;
      end
    end else if (vol_req) begin
      r_pend <= 1'b1;
      r_ppv  <= vol_phone;
      r_psv  <= vol_speak;
    end
  end

endmodule
